exc_sched: RTL and testbench

- Exception/interrupt scheduler for the CP0 coprocessor in the 5-stage MIPS pipeline.
- Synchronizes the external interrupt lines.
- Each cycle, arbitrates between a hardware interrupt, a memory-stage exception and eret.
- Issues a single-cycle take strobe to CP0, then sequences pipeline flush and fetch redirect to either the handler or EPC.

---
 rtl/mips_pkg.sv | 19 +
 rtl/exc_sched_int_sync.sv | 26 ++
 rtl/exc_sched.sv | 111 +++++++++++
 tb/tb_exc_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: CP0 exception codes, the default handler
// entry point and the exception scheduler's state encoding.
package mips_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    REDIR = 2'd2
  } sched_state_t;

endpackage

// File: rtl/exc_sched_int_sync.sv
// Multi-stage flop synchronizer for the external interrupt request lines.
// The output is the last stage, so latency is exactly STAGES cycles.
module int_sync #(
  parameter int STAGES = 2,
  parameter int W      = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/exc_sched.sv
// CP0 exception/interrupt scheduler: arbitrates interrupt > exception > eret,
// strobes CP0, holds flush_all, then redirects fetch to the handler or EPC.
module exc_sched
  import mips_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        m_valid,
  input  logic        exc_req_m,
  input  logic [4:0]  exc_code_m,
  input  logic        bd_m,
  input  logic        eret_m,
  input  logic        sr_ie,
  input  logic        sr_exl,
  input  logic [5:0]  sr_im,
  input  logic [31:0] epc,
  output logic        take_exc,
  output logic [4:0]  exc_code,
  output logic        exc_bd,
  output logic [5:0]  ip_pend,
  output logic        eret_clr,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  sched_state_t state, state_next;
  logic [3:0]   cnt_q, cnt_next;
  logic [31:0]  target_q, target_next;
  logic         int_ok, exc_ok, eret_ok;

  int_sync #(.STAGES(SYNC_STAGES), .W(6)) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (hw_int),
    .q     (ip_pend)
  );

  assign int_ok  = (|(ip_pend & sr_im)) & sr_ie & ~sr_exl & m_valid;
  assign exc_ok  = exc_req_m & m_valid & ~sr_exl;
  assign eret_ok = eret_m & m_valid & sr_exl;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
    end else begin
      state    <= state_next;
      cnt_q    <= cnt_next;
      target_q <= target_next;
    end
  end

  // take_exc, eret_clr and redirect_valid are single-cycle strobes with no
  // back-pressure; their payloads are only meaningful in the strobe cycle.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt_q;
    target_next    = target_q;
    take_exc       = 1'b0;
    exc_code       = '0;
    exc_bd         = 1'b0;
    eret_clr       = 1'b0;
    flush_all      = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (int_ok) begin
          take_exc    = 1'b1;
          exc_code    = EXC_INT;
          exc_bd      = bd_m;
          target_next = HANDLER_ADDR;
        end else if (exc_ok) begin
          take_exc    = 1'b1;
          exc_code    = exc_code_m;
          exc_bd      = bd_m;
          target_next = HANDLER_ADDR;
        end else if (eret_ok) begin
          eret_clr    = 1'b1;
          target_next = epc;
        end
        if (int_ok | exc_ok | eret_ok) begin
          flush_all  = 1'b1;
          cnt_next   = 4'(FLUSH_CYCLES - 1);
          state_next = (FLUSH_CYCLES == 1) ? REDIR : FLUSH;
        end
      end
      FLUSH: begin
        flush_all = 1'b1;
        if (cnt_q != 4'd0) cnt_next = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_next = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign redirect_pc = target_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: a cycle-level model of the event timeline
// checked every cycle, plus literal expectations for the key scenarios.
module tb_exc_sched;

  localparam int          FC      = 2;
  localparam int          SS      = 2;
  localparam logic [31:0] HANDLER = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  hw_int = '0;
  logic        m_valid = 1'b0;
  logic        exc_req_m = 1'b0;
  logic [4:0]  exc_code_m = '0;
  logic        bd_m = 1'b0;
  logic        eret_m = 1'b0;
  logic        sr_ie = 1'b0;
  logic        sr_exl = 1'b0;
  logic [5:0]  sr_im = '0;
  logic [31:0] epc = '0;
  logic        take_exc;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [5:0]  ip_pend;
  logic        eret_clr;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int tests = 0;
  int fails = 0;

  exc_sched #(.HANDLER_ADDR(HANDLER), .FLUSH_CYCLES(FC), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .reset          (reset),
    .hw_int         (hw_int),
    .m_valid        (m_valid),
    .exc_req_m      (exc_req_m),
    .exc_code_m     (exc_code_m),
    .bd_m           (bd_m),
    .eret_m         (eret_m),
    .sr_ie          (sr_ie),
    .sr_exl         (sr_exl),
    .sr_im          (sr_im),
    .epc            (epc),
    .take_exc       (take_exc),
    .exc_code       (exc_code),
    .exc_bd         (exc_bd),
    .ip_pend        (ip_pend),
    .eret_clr       (eret_clr),
    .flush_all      (flush_all),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: hw_int history for the synchronizer delay, and the age of the
  // current event (0 = idle, 1..FC = cycles since it was accepted).
  logic [5:0]  hw_q[$];
  logic [31:0] exp_q[$];
  int          ev_age = 0;
  logic [5:0]  m_ip;
  logic        m_int, m_exc, m_eret, m_acc, m_rv;
  logic [4:0]  m_code;
  logic [31:0] m_pc;

  always @(negedge clk) begin
    if (reset) begin
      ev_age = 0;
      hw_q.delete();
      for (int i = 0; i < SS; i++) hw_q.push_front(6'h00);
      exp_q.delete();
    end else begin
      m_ip   = hw_q[SS-1];
      m_int  = (ev_age == 0) && (|(m_ip & sr_im)) && sr_ie && !sr_exl && m_valid;
      m_exc  = (ev_age == 0) && !m_int && exc_req_m && m_valid && !sr_exl;
      m_eret = (ev_age == 0) && !m_int && !m_exc && eret_m && m_valid && sr_exl;
      m_acc  = m_int || m_exc || m_eret;
      m_code = m_exc ? exc_code_m : 5'd0;
      m_rv   = (ev_age == FC);
      chk("ip_pend", ip_pend, m_ip);
      chk("take_exc", take_exc, m_int || m_exc);
      chk("exc_code", exc_code, m_code);
      chk("exc_bd", exc_bd, (m_int || m_exc) ? bd_m : 1'b0);
      chk("eret_clr", eret_clr, m_eret);
      chk("flush_all", flush_all, m_acc || (ev_age >= 1 && ev_age < FC));
      chk("redirect_valid", redirect_valid, m_rv);
      chk("busy", busy, ev_age != 0);
      if (m_rv) begin
        if (exp_q.size() == 0) chk("redirect_target_known", 32'd0, 32'd1);
        else begin
          m_pc = exp_q.pop_front();
          chk("redirect_pc", redirect_pc, m_pc);
        end
      end
      if (m_acc) exp_q.push_back(m_eret ? epc : HANDLER);
      if (m_acc) ev_age = 1;
      else if (ev_age >= 1 && ev_age < FC) ev_age = ev_age + 1;
      else ev_age = 0;
      hw_q.push_front(hw_int);
      void'(hw_q.pop_back());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    m_valid = 1'b0; exc_req_m = 1'b0; exc_code_m = '0; bd_m = 1'b0; eret_m = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_take", take_exc, 0);
    chk("rst_flush", flush_all, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_ip", ip_pend, 6'h00);
    chk("rst_busy", busy, 0);

    // IRQ path: one-cycle pulse on line 0
    sr_ie = 1; sr_im = 6'h01; sr_exl = 0; m_valid = 1;
    tick(); hw_int = 6'h01;
    @(negedge clk); chk("irq_c0_take", take_exc, 0);
    tick(); hw_int = 6'h00;
    @(negedge clk); chk("irq_c1_take", take_exc, 0);
    tick();
    @(negedge clk);
    chk("irq_c2_ip", ip_pend, 6'h01);
    chk("irq_c2_take", take_exc, 1);
    chk("irq_c2_code", exc_code, 0);
    chk("irq_c2_flush", flush_all, 1);
    tick();
    @(negedge clk); chk("irq_c3_flush", flush_all, 1); chk("irq_c3_take", take_exc, 0);
    tick();
    @(negedge clk);
    chk("irq_c4_rv", redirect_valid, 1);
    chk("irq_c4_pc", redirect_pc, 32'h4180);
    chk("irq_c4_flush", flush_all, 0);
    tick(); quiet(); sr_im = 6'h00;

    // Exception held through flush: a second take only once busy drops
    tick(); m_valid = 1; exc_req_m = 1; exc_code_m = 5'd12; bd_m = 1;
    @(negedge clk);
    chk("exc_take", take_exc, 1); chk("exc_code", exc_code, 12); chk("exc_bd", exc_bd, 1);
    tick(); @(negedge clk); chk("exc_hold_t1", take_exc, 0);
    tick(); @(negedge clk);
    chk("exc_hold_t2", take_exc, 0); chk("exc_rv", redirect_valid, 1);
    chk("exc_pc", redirect_pc, 32'h4180); chk("exc_busy_t2", busy, 1);
    tick(); @(negedge clk); chk("exc_retake", take_exc, 1); chk("exc_retake_code", exc_code, 12);
    tick(); quiet();
    repeat (3) tick();

    // Priority: interrupt synchronized while m_valid=0, then exc code 10 arrives
    sr_im = 6'h01; hw_int = 6'h01;
    tick(); tick(); tick();
    @(negedge clk); chk("prio_gated", take_exc, 0);
    tick(); m_valid = 1; exc_req_m = 1; exc_code_m = 5'd10; bd_m = 0;
    @(negedge clk); chk("prio_take", take_exc, 1); chk("prio_code", exc_code, 0);
    tick(); quiet(); hw_int = 6'h00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("prio_single", take_exc, 0);
      tick();
    end

    // eret with EXL set, then with EXL clear
    sr_exl = 1; epc = 32'h0000_3008; m_valid = 1; eret_m = 1;
    @(negedge clk); chk("eret_clr", eret_clr, 1); chk("eret_take", take_exc, 0);
    tick(); quiet();
    tick(); @(negedge clk); chk("eret_rv", redirect_valid, 1); chk("eret_pc", redirect_pc, 32'h3008);
    tick(); sr_exl = 0; m_valid = 1; eret_m = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("eret_noexl_clr", eret_clr, 0); chk("eret_noexl_busy", busy, 0);
      tick();
    end
    quiet();

    // Masking: im=0, ie=0, exl=1 each block an asserted interrupt; exl blocks exceptions
    hw_int = 6'h3F; m_valid = 1; sr_im = 6'h00; sr_ie = 1; sr_exl = 0;
    for (int i = 0; i < 4; i++) begin tick(); @(negedge clk); chk("mask_im", take_exc, 0); end
    sr_im = 6'h3F; sr_ie = 0;
    for (int i = 0; i < 2; i++) begin tick(); @(negedge clk); chk("mask_ie", take_exc, 0); end
    sr_ie = 1; sr_exl = 1; exc_req_m = 1; exc_code_m = 5'd4;
    for (int i = 0; i < 2; i++) begin tick(); @(negedge clk); chk("mask_exl", take_exc, 0); end
    tick(); quiet(); sr_exl = 0; sr_im = 6'h00;

    // Reset during FLUSH discards the pending redirect and clears ip_pend
    tick(); m_valid = 1; exc_req_m = 1; exc_code_m = 5'd5;
    @(negedge clk); chk("rstf_take", take_exc, 1);
    tick(); quiet(); reset = 1;
    tick(); reset = 0;
    @(negedge clk);
    chk("rstf_busy", busy, 0); chk("rstf_flush", flush_all, 0);
    chk("rstf_rv", redirect_valid, 0); chk("rstf_ip", ip_pend, 6'h00);
    chk("rstf_pc", redirect_pc, 32'h0);
    tick(); hw_int = 6'h00;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
